// File: rtl/vblank_update_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : vblank_update_arbiter_if
// Purpose : Bundle of the raster position, client handshake and status
//           signals exchanged with vblank_update_arbiter.
// Rev     : 1.0
// ============================================================================
interface vblank_update_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [15:0]      row;
    logic [15:0]      column;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic             frame_tick;
    logic [15:0]      frame_count;
    logic             overrun;
    logic [7:0]       overrun_count;
    logic             busy;

    modport master (
        output row, column, req, done,
        input  gnt, frame_tick, frame_count, overrun, overrun_count, busy
    );

    modport slave (
        input  row, column, req, done,
        output gnt, frame_tick, frame_count, overrun, overrun_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/vblank_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vblank_update_arbiter
// Purpose : Round-robin grant of one shared update slot inside vertical
//           blanking, with frame counting and overrun detection.
// Rev     : 1.0
// ============================================================================
module vblank_update_arbiter #(
    parameter int N_REQ       = 4,
    parameter int V_VISIBLE   = 600,
    parameter int V_TOTAL     = 628,
    parameter int GUARD_LINES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    vblank_update_arbiter_if.slave  if_bus
);
    localparam int               IDX_W         = $clog2(N_REQ);
    localparam logic [15:0]      c_row_vis     = 16'(V_VISIBLE);
    localparam logic [15:0]      c_row_win_end = 16'(V_TOTAL - GUARD_LINES);
    localparam logic [IDX_W-1:0] c_last_idx    = IDX_W'(N_REQ - 1);
    localparam logic [IDX_W:0]   c_n_req       = (IDX_W+1)'(N_REQ);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_ARB    = 2'd1,
        ST_GRANT  = 2'd2,
        ST_LATE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_served;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic               r_frame_tick;
    logic [15:0]        r_frame_count;
    logic               r_overrun;
    logic [7:0]         r_overrun_count;

    state_t             w_state_nxt;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [N_REQ-1:0]   w_served_nxt;
    logic [IDX_W-1:0]   w_rr_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_tick_nxt;
    logic [15:0]        w_fc_nxt;
    logic               w_ovr_nxt;
    logic [7:0]         w_oc_nxt;

    logic               w_vb_start;
    logic               w_fr_start;
    logic               w_window_open;
    logic [N_REQ-1:0]   w_eligible;
    logic               w_done_hit;
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W:0]     w_k;
    logic [IDX_W-1:0]   w_after_idx;

    assign w_vb_start    = (if_bus.row == c_row_vis) && (if_bus.column == 16'd0);
    assign w_fr_start    = (if_bus.row == 16'd0) && (if_bus.column == 16'd0);
    assign w_window_open = (if_bus.row >= c_row_vis) && (if_bus.row <= c_row_win_end);
    assign w_eligible    = if_bus.req & ~r_served;
    assign w_done_hit    = if_bus.done[r_idx];
    assign w_after_idx   = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

    // Rotating search: first eligible index at or after r_rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        w_k      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_k = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
            if (w_k >= c_n_req) begin
                w_k = w_k - c_n_req;
            end
            if (!w_found && w_eligible[w_k[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_k[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_served_nxt = r_served;
        w_rr_nxt     = r_rr_ptr;
        w_idx_nxt    = r_idx;
        w_tick_nxt   = 1'b0;
        w_fc_nxt     = r_frame_count;
        w_ovr_nxt    = 1'b0;
        w_oc_nxt     = r_overrun_count;
        case (r_state)
            ST_ACTIVE: begin
                if (w_vb_start) begin
                    w_state_nxt  = ST_ARB;
                    w_tick_nxt   = 1'b1;
                    w_fc_nxt     = r_frame_count + 16'd1;
                    w_served_nxt = '0;
                end
            end
            ST_ARB: begin
                if (w_fr_start) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_window_open && w_found) begin
                    w_state_nxt         = ST_GRANT;
                    w_gnt_nxt           = '0;
                    w_gnt_nxt[w_winner] = 1'b1;
                    w_idx_nxt           = w_winner;
                end
            end
            ST_GRANT: begin
                // Completion takes priority over a coincident frame start.
                if (w_done_hit) begin
                    w_gnt_nxt           = '0;
                    w_served_nxt[r_idx] = 1'b1;
                    w_rr_nxt            = w_after_idx;
                    w_state_nxt         = w_fr_start ? ST_ACTIVE : ST_ARB;
                end else if (w_fr_start) begin
                    w_ovr_nxt   = 1'b1;
                    w_oc_nxt    = (r_overrun_count == 8'hFF) ? 8'hFF : r_overrun_count + 8'd1;
                    w_state_nxt = ST_LATE;
                end
            end
            ST_LATE: begin
                if (w_done_hit) begin
                    w_gnt_nxt           = '0;
                    w_served_nxt[r_idx] = 1'b1;
                    w_rr_nxt            = w_after_idx;
                    w_state_nxt         = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_ACTIVE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_ACTIVE;
            r_gnt           <= '0;
            r_served        <= '0;
            r_rr_ptr        <= '0;
            r_idx           <= '0;
            r_frame_tick    <= 1'b0;
            r_frame_count   <= 16'd0;
            r_overrun       <= 1'b0;
            r_overrun_count <= 8'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_gnt           <= w_gnt_nxt;
            r_served        <= w_served_nxt;
            r_rr_ptr        <= w_rr_nxt;
            r_idx           <= w_idx_nxt;
            r_frame_tick    <= w_tick_nxt;
            r_frame_count   <= w_fc_nxt;
            r_overrun       <= w_ovr_nxt;
            r_overrun_count <= w_oc_nxt;
        end
    end

    assign if_bus.gnt           = r_gnt;
    assign if_bus.frame_tick    = r_frame_tick;
    assign if_bus.frame_count   = r_frame_count;
    assign if_bus.overrun       = r_overrun;
    assign if_bus.overrun_count = r_overrun_count;
    assign if_bus.busy          = (r_state == ST_GRANT) || (r_state == ST_LATE);

endmodule
`default_nettype wire
